// File: rtl/mem_line_responder.sv
// mem_line_responder
//
// Fixed-latency line memory responder. It accepts one request at a time
// from IDLE. The response comes back LAT cycles later as a one-cycle
// mem_ready_o strobe carrying the line data. Writes store the line and
// echo it back. Reads return the stored line.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   mem_req_valid_i request pending, sampled only in IDLE
//   mem_req_rw_i    1 = line write, 0 = line read
//   mem_req_addr_i  byte address; bits [AW+3:4] select the line
//   mem_req_data_i  write line data
//   mem_data_o      response line data, held between responses
//   mem_ready_o     one-cycle response strobe
//   busy_o          transaction in progress
//   rd_cnt_o        completed reads (wrapping)
//   wr_cnt_o        completed writes (wrapping)
//
// state | meaning
// IDLE  | waiting for a request; inputs are sampled here only
// BUSY  | latency countdown for the accepted request
// RESP  | mem_ready_o high for one cycle, data valid on mem_data_o

module mem_line_responder #(
    parameter int LAT   = 4,
    parameter int DEPTH = 256
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         mem_req_valid_i,
    input  logic         mem_req_rw_i,
    input  logic [31:0]  mem_req_addr_i,
    input  logic [127:0] mem_req_data_i,
    output logic [127:0] mem_data_o,
    output logic         mem_ready_o,
    output logic         busy_o,
    output logic [31:0]  rd_cnt_o,
    output logic [31:0]  wr_cnt_o
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q;
    logic            rw_q;
    logic [AW-1:0]   idx_q;
    logic [127:0]    wdata_q;
    logic [127:0]    mem_q [DEPTH];

    logic            accept;
    logic            enter_resp;
    logic            tx_rw;
    logic [AW-1:0]   tx_idx;
    logic [127:0]    tx_data;

    // Address bits outside the line index are deliberately ignored.
    logic            unused_addr;
    assign unused_addr = ^{mem_req_addr_i[31:AW+4], mem_req_addr_i[3:0]};

    // With LAT=1 the accepting edge is also the RESP-entry edge, so the
    // transaction fields must come straight from the inputs in that case.
    assign tx_rw   = (state_q == IDLE) ? mem_req_rw_i              : rw_q;
    assign tx_idx  = (state_q == IDLE) ? mem_req_addr_i[AW+3:4]    : idx_q;
    assign tx_data = (state_q == IDLE) ? mem_req_data_i            : wdata_q;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_valid_i) begin
                    accept = 1'b1;
                    if (LAT == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 8'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            mem_data_o <= '0;
            rd_cnt_o   <= '0;
            wr_cnt_o   <= '0;
        end else begin
            if (accept) begin
                cnt_q   <= LAT_M1;
                rw_q    <= mem_req_rw_i;
                idx_q   <= mem_req_addr_i[AW+3:4];
                wdata_q <= mem_req_data_i;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (enter_resp) begin
                if (tx_rw) begin
                    mem_data_o <= tx_data;
                    wr_cnt_o   <= wr_cnt_o + 32'd1;
                end else begin
                    mem_data_o <= mem_q[tx_idx];
                    rd_cnt_o   <= rd_cnt_o + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (enter_resp && tx_rw) begin
            mem_q[tx_idx] <= tx_data;
        end
    end

    assign mem_ready_o = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_line_responder.sv
module tb_mem_line_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         vld = 1'b0, rw = 1'b0;
    logic [31:0]  addr = '0;
    logic [127:0] wdat = '0;
    logic [127:0] rdat;
    logic         rdy, busy;
    logic [31:0]  rd_cnt, wr_cnt;

    logic         v1 = 1'b0, rw1 = 1'b0;
    logic [31:0]  a1 = '0;
    logic [127:0] d1 = '0;
    logic [127:0] rdat1;
    logic         rdy1, busy1;
    logic [31:0]  rd1, wr1;

    mem_line_responder #(.LAT(LAT), .DEPTH(256)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .mem_req_valid_i(vld), .mem_req_rw_i(rw),
        .mem_req_addr_i(addr), .mem_req_data_i(wdat),
        .mem_data_o(rdat), .mem_ready_o(rdy), .busy_o(busy),
        .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
    );

    mem_line_responder #(.LAT(1), .DEPTH(256)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni),
        .mem_req_valid_i(v1), .mem_req_rw_i(rw1),
        .mem_req_addr_i(a1), .mem_req_data_i(d1),
        .mem_data_o(rdat1), .mem_ready_o(rdy1), .busy_o(busy1),
        .rd_cnt_o(rd1), .wr_cnt_o(wr1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [127:0] d;
        logic [31:0]  rd;
        logic [31:0]  wr;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] mdl [256];
    logic [31:0]  rd_m = 0, wr_m = 0;
    int           cur_a = -100;
    int           next_free = 0;
    bit           held = 0;
    int           n_vec = 0, n_err = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mdl[i] = '0;
        rd_m = 0;
        wr_m = 0;
        exp_q.delete();
        cur_a = -100;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input logic r, input logic [31:0] a, input logic [127:0] d,
                         input bit keep, input bit scram);
        logic [7:0]   idx;
        logic [127:0] ed;
        int           acc;
        if (!held) repeat ($urandom_range(0, 2)) @(negedge clk);
        while (cyc + 1 < next_free) @(negedge clk);
        vld = 1'b1; rw = r; addr = a; wdat = d;
        acc       = cyc + 1;
        cur_a     = acc;
        next_free = acc + LAT + 1;
        idx       = a[11:4];
        if (r) begin
            mdl[idx] = d;
            wr_m     = wr_m + 1;
            ed       = d;
        end else begin
            rd_m = rd_m + 1;
            ed   = mdl[idx];
        end
        exp_q.push_back('{acc + LAT - 1, ed, rd_m, wr_m});
        @(posedge clk);
        @(negedge clk);
        if (scram) begin
            addr = $urandom; wdat = rnd128(); rw = ~rw;
        end
        if (!keep) vld = 1'b0;
        held = keep;
    endtask

    // Monitor: per-cycle strobe/busy timing plus scoreboard on each response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (rst_ni) begin
                check("busy", 128'(busy), 128'((cyc >= cur_a) && (cyc <= cur_a + LAT - 1)));
                check("ready", 128'(rdy), 128'(cyc == cur_a + LAT - 1));
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ready", 128'(1), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_cycle", 128'(cyc), 128'(e.c));
                        check("resp_data", rdat, e.d);
                        check("rd_cnt", 128'(rd_cnt), 128'(e.rd));
                        check("wr_cnt", 128'(wr_cnt), 128'(e.wr));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0]  ra;
        logic [127:0] w [3];
        model_reset();

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 128'(rdy), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_data", rdat, 128'(0));
        check("rst_rd", 128'(rd_cnt), 128'(0));
        check("rst_wr", 128'(wr_cnt), 128'(0));
        @(negedge clk);
        rst_ni    = 1'b1;
        next_free = cyc + 1;
        held      = 1;          // first request on the first edge after release

        // Read after reset, write then aliased read
        issue(1'b0, 32'h0000_0120, rnd128(), 0, 0);
        issue(1'b1, 32'h0000_0120, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0, 0);
        issue(1'b0, 32'h0001_0128, rnd128(), 0, 0);

        // Write-back then allocate with valid held high
        issue(1'b1, 32'h0000_0300, rnd128(), 1, 0);
        issue(1'b0, 32'h0000_0300, rnd128(), 0, 0);

        // Drop valid and scramble inputs mid-BUSY
        issue(1'b1, 32'h0000_0040, rnd128(), 0, 1);
        issue(1'b0, 32'h0000_0040, rnd128(), 0, 1);

        // Random traffic over a few lines with aliasing upper bits
        for (int i = 0; i < 40; i++) begin
            ra       = $urandom;
            ra[11:4] = 8'($urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), ra, rnd128(),
                  (i != 39) && ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end
        repeat (LAT + 3) @(negedge clk);
        check("drain1", 128'(exp_q.size()), 128'(0));

        // Reset in BUSY of a write to line 5
        issue(1'b1, 32'h0000_0050, rnd128(), 0, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", 128'(rdy), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_data", rdat, 128'(0));
        check("mid_rst_wr", 128'(wr_cnt), 128'(0));
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni    = 1'b1;
        next_free = cyc + 1;
        held      = 0;
        issue(1'b0, 32'h0000_0050, rnd128(), 0, 0);
        repeat (LAT + 3) @(negedge clk);
        check("drain2", 128'(exp_q.size()), 128'(0));
        check("post_rst_wr", 128'(wr_cnt), 128'(0));
        check("post_rst_rd", 128'(rd_cnt), 128'(1));

        // LAT=1 instance: sustained valid, alternating write/read per line
        for (int j = 0; j < 3; j++) w[j] = rnd128();
        @(negedge clk);
        v1 = 1'b1; rw1 = 1'b1; a1 = 32'h0000_0020; d1 = w[0];
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("l1_ready", 128'(rdy1), 128'(k % 2 == 0));
            check("l1_busy", 128'(busy1), 128'(k % 2 == 0));
            if (k % 2 == 0) begin
                check("l1_data", rdat1, w[k / 4]);
                if (k / 2 + 1 == 6) begin
                    v1 = 1'b0;
                end else begin
                    rw1 = ((k / 2 + 1) % 2 == 0);
                    a1  = 32'((k / 4 + (((k / 2 + 1) % 2 == 0) ? 1 : 0) + 2) * 16)
                          | 32'h00F0_0000;
                    d1  = rw1 ? w[(k / 2 + 1) / 2] : rnd128();
                end
            end
        end
        check("l1_rd", 128'(rd1), 128'(3));
        check("l1_wr", 128'(wr1), 128'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
